// File: rtl/act_buf_stream_reader.sv
// Read sequencer for the activation buffer's port B. It turns {base, count, stride}
// commands into read strobes and streams the returned words to the PE array.
module act_buf_stream_reader #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 13,
    parameter int CNT_WIDTH  = 16,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic [ADDR_WIDTH-1:0] addr_stride,
    output logic                  busy,
    output logic                  done,
    output logic                  b_en,
    output logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic [CNT_WIDTH-1:0]    num_words_q;
    logic [ADDR_WIDTH-1:0]   stride_q;
    logic [CNT_WIDTH-1:0]    issue_cnt_q;
    logic [ADDR_WIDTH-1:0]   b_addr_q;

    logic [RD_LATENCY-1:0]   vld_sr;
    logic [RD_LATENCY-1:0]   last_sr;

    logic [DATA_WIDTH-1:0]   data_mem [FIFO_DEPTH];
    logic                    last_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]       fifo_count;

    logic [OCC_W-1:0]        inflight;
    logic [OCC_W-1:0]        occupancy;
    logic                    credit_ok;
    logic                    start_accept;
    logic                    issue_last;
    logic                    push, pop;
    logic                    fifo_empty, fifo_full;

    assign start_accept = (state_q == IDLE) && start && !abort && (num_words != '0);
    assign issue_last   = (issue_cnt_q == num_words_q - CNT_WIDTH'(1));

    // Outstanding words = in the FIFO + still in the read pipeline; an issue is only
    // allowed when a slot is guaranteed for its return, so PE backpressure never drops data.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + OCC_W'(vld_sr[i]);
        end
    end

    assign occupancy = OCC_W'(fifo_count) + inflight;
    assign credit_ok = occupancy < OCC_W'(FIFO_DEPTH);

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FCNT_W'(FIFO_DEPTH));
    assign push       = vld_sr[RD_LATENCY-1];
    assign pop        = m_valid && m_ready;

    assign b_en    = (state_q == RUN) && credit_ok && !abort;
    assign b_addr  = b_addr_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? data_mem[rd_ptr] : '0;
    assign m_last  = m_valid && last_mem[rd_ptr];

    // NOTE: every variable gets a default before the case, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            done_d  = (state_q != IDLE);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_words != '0) state_d = RUN;
                        else                 done_d  = 1'b1;
                    end
                end
                RUN: begin
                    if (b_en && issue_last) state_d = DRAIN;
                end
                DRAIN: begin
                    // The final-flagged entry is the last word issued, so once it
                    // leaves the FIFO nothing else can be queued or in flight.
                    if (pop && m_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            num_words_q <= '0;
            stride_q    <= '0;
            issue_cnt_q <= '0;
            b_addr_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (start_accept) begin
                num_words_q <= num_words;
                stride_q    <= addr_stride;
                issue_cnt_q <= '0;
                b_addr_q    <= base_addr;
            end else if (b_en) begin
                issue_cnt_q <= issue_cnt_q + CNT_WIDTH'(1);
                b_addr_q    <= b_addr_q + stride_q;
            end
        end
    end

    // Read-return tracking and FIFO bookkeeping; abort discards anything still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr     <= '0;
            last_sr    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (abort) begin
            vld_sr     <= '0;
            last_sr    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            vld_sr[0]  <= b_en;
            last_sr[0] <= b_en && issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; the count and pointers alone decide validity.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= b_rdata;
            last_mem[wr_ptr] <= last_sr[RD_LATENCY-1];
        end
    end

    push_into_full_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_act_buf_stream_reader.sv
// Self-checking bench for act_buf_stream_reader: table of commands plus directed
// sequences for zero length, abort, async reset and a long random-ready stream.
module tb_act_buf_stream_reader;

    localparam int DW    = 128;
    localparam int AW    = 13;
    localparam int CW    = 16;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, m_ready;
    logic [AW-1:0] base_addr, addr_stride;
    logic [CW-1:0] num_words;
    logic          busy, done, b_en, m_valid, m_last;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_rdata, m_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW-1:0] addr_log[$];

    typedef struct {
        logic [AW-1:0] base;
        logic [CW-1:0] num;
        logic [AW-1:0] stride;
        int            ready_pct;
        int            stall_after;
        logic [AW-1:0] exp_last_addr;
    } vec_t;

    act_buf_stream_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
        .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .num_words(num_words), .addr_stride(addr_stride),
        .busy(busy), .done(done), .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {16'hA5C3, 3'b000, a, 32'(a) * 32'h9E3779B1, ~{19'h0, a}, 32'h0BADF00D ^ {19'h0, a}};
    endfunction

    // Single-cycle-latency buffer model; junk on idle cycles exposes misaligned capture.
    always @(posedge clk) begin
        if (b_en) b_rdata <= word_of(b_addr);
        else      b_rdata <= {4{32'hDEADBEEF}};
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ctrl"}, DW'({busy, done, b_en, m_valid, m_last}), '0);
        check({tag, " b_addr"}, DW'(b_addr), '0);
        check({tag, " m_data"}, m_data, '0);
    endtask

    task automatic run_cmd(input logic [AW-1:0] base, input logic [CW-1:0] num,
                           input logic [AW-1:0] stride, input int ready_pct,
                           input int stall_after, input string tag);
        int issued, beats, cyc, stall_left, first_en, first_vld, last_hs;
        bit hs_last_prev, finished, stalled_once, prev_valid, prev_ready;
        logic [DW-1:0] prev_data;
        logic [AW-1:0] exp_addr;
        addr_log.delete();
        issued = 0; beats = 0; cyc = 0; stall_left = 0;
        first_en = -1; first_vld = -1; last_hs = -1;
        hs_last_prev = 0; finished = 0; stalled_once = 0;
        prev_valid = 0; prev_ready = 0; prev_data = '0;
        @(negedge clk);
        start = 1'b1; base_addr = base; num_words = num; addr_stride = stride;
        @(negedge clk);
        start = 1'b0; base_addr = '0; num_words = '0; addr_stride = '0;
        while (!finished && cyc < 6000) begin
            if (!stalled_once && stall_after >= 0 && beats == stall_after) begin
                stall_left   = 10;
                stalled_once = 1;
            end
            m_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < ready_pct);
            #1;
            if (cyc == 0) check({tag, " busy_on_start"}, DW'(busy), DW'(1));
            check({tag, " done"}, DW'(done), DW'(hs_last_prev));
            if (hs_last_prev) begin
                check({tag, " busy_at_done"}, DW'(busy), '0);
                finished = 1;
            end else begin
                if (prev_valid && !prev_ready) begin
                    check({tag, " stall_valid"}, DW'(m_valid), DW'(1));
                    check({tag, " stall_data"}, m_data, prev_data);
                end
                if (b_en) begin
                    if (first_en < 0) first_en = cyc;
                    exp_addr = base + AW'(issued) * stride;
                    check({tag, " b_addr"}, DW'(b_addr), DW'(exp_addr));
                    check({tag, " credit"}, DW'(issued - beats < DEPTH), DW'(1));
                    addr_log.push_back(b_addr);
                    issued++;
                end
                if (m_valid && first_vld < 0) first_vld = cyc;
                if (m_valid && m_ready) begin
                    check({tag, " m_data"}, m_data, word_of(base + AW'(beats) * stride));
                    check({tag, " m_last"}, DW'(m_last), DW'(beats == int'(num) - 1));
                    hs_last_prev = (beats == int'(num) - 1);
                    last_hs = cyc;
                    beats++;
                end
                if (stall_left == 1) begin
                    check({tag, " stall_b_en"}, DW'(b_en), '0);
                    check({tag, " stall_outstanding"}, DW'(issued - beats), DW'(DEPTH));
                end
            end
            prev_valid = m_valid; prev_ready = m_ready; prev_data = m_data;
            if (stall_left > 0) stall_left--;
            @(negedge clk);
            cyc++;
        end
        check({tag, " finished_in_time"}, DW'(finished), DW'(1));
        check({tag, " issued"}, DW'(issued), DW'(num));
        check({tag, " beats"}, DW'(beats), DW'(num));
        check({tag, " first_issue"}, DW'(first_en), '0);
        check({tag, " latency"}, DW'(first_vld - first_en), DW'(LAT + 1));
        if (ready_pct == 100 && stall_after < 0)
            check({tag, " throughput"}, DW'(last_hs - first_vld), DW'(int'(num) - 1));
        #1;
        check({tag, " done_pulse_end"}, DW'(done), '0);
        m_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        logic [AW-1:0] exp_wrap[4];
        int beats, cyc;

        vecs[0] = '{base: 13'h0010, num: 16'd8,  stride: 13'h001, ready_pct: 100, stall_after: -1, exp_last_addr: 13'h0017};
        vecs[1] = '{base: 13'h0100, num: 16'd1,  stride: 13'h007, ready_pct: 100, stall_after: -1, exp_last_addr: 13'h0100};
        vecs[2] = '{base: 13'h0200, num: 16'd6,  stride: 13'h010, ready_pct: 100, stall_after: -1, exp_last_addr: 13'h0250};
        vecs[3] = '{base: 13'h0400, num: 16'd16, stride: 13'h001, ready_pct: 100, stall_after: 1,  exp_last_addr: 13'h040F};
        vecs[4] = '{base: 13'h1F00, num: 16'd20, stride: 13'h020, ready_pct: 60,  stall_after: -1, exp_last_addr: 13'h0160};
        exp_wrap = '{13'h1FFE, 13'h0001, 13'h0004, 13'h0007};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        base_addr = '0; num_words = '0; addr_stride = '0;
        repeat (3) @(negedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_idle_outputs("post_reset");

        for (int i = 0; i < 5; i++) begin
            run_cmd(vecs[i].base, vecs[i].num, vecs[i].stride, vecs[i].ready_pct,
                    vecs[i].stall_after, $sformatf("vec%0d", i));
            check($sformatf("vec%0d last_addr", i), DW'(addr_log[$]), DW'(vecs[i].exp_last_addr));
        end

        run_cmd(13'h1FFE, 16'd4, 13'h003, 100, -1, "wrap");
        for (int i = 0; i < 4; i++)
            check($sformatf("wrap addr%0d", i), DW'(addr_log[i]), DW'(exp_wrap[i]));

        // Zero-length command.
        @(negedge clk);
        start = 1'b1; base_addr = 13'h0055; num_words = '0; addr_stride = 13'h001;
        #1 check("zero b_en_start", DW'(b_en), '0);
        @(negedge clk);
        start = 1'b0;
        #1 check("zero done", DW'({done, busy, b_en}), DW'(3'b100));
        @(negedge clk);
        #1 check("zero after", DW'({done, busy, b_en}), '0);

        // Abort mid-stream; a stray start while busy and a start alongside abort are ignored.
        @(negedge clk);
        start = 1'b1; base_addr = 13'h0800; num_words = 16'd32; addr_stride = 13'h001; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 5 && cyc < 100) begin
            if (cyc == 2) begin
                start = 1'b1; base_addr = 13'h1000; num_words = 16'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            check("abort pre_done", DW'(done), '0);
            if (m_valid && m_ready) begin
                check("abort m_data", m_data, word_of(13'h0800 + AW'(beats)));
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        check("abort reached_beat5", DW'(beats), DW'(5));
        abort = 1'b1; start = 1'b1; base_addr = 13'h0300; num_words = 16'd5;
        #1 check("abort b_en_comb", DW'(b_en), '0);
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        #1 check("abort next", DW'({m_valid, done, busy}), DW'(3'b010));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 check($sformatf("abort quiet%0d", i), DW'({m_valid, done, busy, b_en}), '0);
        end
        run_cmd(13'h0900, 16'd2, 13'h001, 100, -1, "restart");

        // Asynchronous reset in the middle of a command.
        @(negedge clk);
        start = 1'b1; base_addr = 13'h0040; num_words = 16'd8; addr_stride = 13'h001; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("after_reset%0d", i), DW'({done, busy, m_valid, b_en}), '0);
            @(negedge clk);
        end
        m_ready = 1'b0;

        run_cmd(13'h0123, 16'd1000, 13'h005, 50, -1, "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
